// File: rtl/mult_div.sv
// Multicycle signed multiply/divide unit producing the HI/LO registers.
// Latency: 32 cycles from the accepting edge to done; divide-by-zero completes at the accepting edge.
// Backpressure: start is accepted only while busy=0; starts during an operation are ignored.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   start, op         request pulse; op 0 = MULT (Booth radix-2), 1 = DIV (restoring)
//   a_in, b_in        signed operands (multiplicand/dividend, multiplier/divisor)
//   hi_out, lo_out    product[63:32]/[31:0], or remainder/quotient
//   busy, done        operation in progress / one-cycle completion pulse
//   div_zero          last accepted DIV had a zero divisor
module mult_div (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t      state;
    logic [5:0]  cnt;

    // Shared datapath. MULT: acc/q/qm1 form the Booth register, m is the
    // signed multiplicand. DIV: acc is the partial remainder, q shifts the
    // dividend magnitude out and the quotient in, m is the divisor magnitude.
    // acc carries one guard bit so that subtracting a multiplicand of
    // 0x80000000 cannot overflow.
    logic [32:0] acc;
    logic [31:0] q;
    logic        qm1;
    logic [31:0] m;
    logic        neg_q;
    logic        neg_r;

    // Magnitudes of the incoming operands for the divider
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    always_comb begin
        a_abs = a_in[31] ? (~a_in + 32'd1) : a_in;
        b_abs = b_in[31] ? (~b_in + 32'd1) : b_in;
    end

    // Booth step
    logic [32:0] booth_sum;
    logic [32:0] mul_acc_n;
    logic [31:0] mul_q_n;
    logic        mul_qm1_n;

    always_comb begin
        booth_sum = acc;
        case ({q[0], qm1})
            2'b01:   booth_sum = acc + {m[31], m};
            2'b10:   booth_sum = acc - {m[31], m};
            default: booth_sum = acc;
        endcase
        // Arithmetic shift of the whole {acc, q, qm1} register
        mul_acc_n = {booth_sum[32], booth_sum[32:1]};
        mul_q_n   = {booth_sum[0], q[31:1]};
        mul_qm1_n = q[0];
    end

    // Restoring divide step
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [32:0] div_rem_n;
    logic [31:0] div_quo_n;
    logic [31:0] div_quo_fin;
    logic [31:0] div_rem_fin;

    always_comb begin
        div_shift = {acc[31:0], q[31]};
        div_diff  = div_shift - {1'b0, m};
        if (!div_diff[32]) begin
            div_rem_n = div_diff;
            div_quo_n = {q[30:0], 1'b1};
        end else begin
            div_rem_n = div_shift;
            div_quo_n = {q[30:0], 1'b0};
        end
        // Quotient truncates toward zero; remainder follows the dividend sign.
        // 0x80000000 / -1 wraps back to 0x80000000 through the negation.
        div_quo_fin = neg_q ? (~div_quo_n + 32'd1) : div_quo_n;
        div_rem_fin = neg_r ? (~div_rem_n[31:0] + 32'd1) : div_rem_n[31:0];
    end

    logic last_iter;
    assign last_iter = (cnt == 6'd31);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 6'd0;
            acc      <= 33'd0;
            q        <= 32'd0;
            qm1      <= 1'b0;
            m        <= 32'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi_out   <= 32'd0;
            lo_out   <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt      <= 6'd0;
                        div_zero <= 1'b0;
                        acc      <= 33'd0;
                        qm1      <= 1'b0;
                        if (!op) begin
                            m     <= a_in;
                            q     <= b_in;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= MULT;
                            busy  <= 1'b1;
                        end else begin
                            m     <= b_abs;
                            q     <= a_abs;
                            neg_q <= a_in[31] ^ b_in[31];
                            neg_r <= a_in[31];
                            if (b_in == 32'd0) begin
                                // Zero divisor completes immediately, HI/LO untouched
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                            end else begin
                                state <= DIV;
                                busy  <= 1'b1;
                            end
                        end
                    end
                end
                MULT: begin
                    acc <= mul_acc_n;
                    q   <= mul_q_n;
                    qm1 <= mul_qm1_n;
                    cnt <= cnt + 6'd1;
                    if (last_iter) begin
                        hi_out <= mul_acc_n[31:0];
                        lo_out <= mul_q_n;
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                DIV: begin
                    acc <= div_rem_n;
                    q   <= div_quo_n;
                    cnt <= cnt + 6'd1;
                    if (last_iter) begin
                        hi_out <= div_rem_fin;
                        lo_out <= div_quo_fin;
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
module tb_mult_div;

    logic        clock;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        busy;
    logic        done;
    logic        div_zero;

    int checks   = 0;
    int failures = 0;

    mult_div dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a_in     (a_in),
        .b_in     (b_in),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Pulse start for one edge (E0), then count edges until done, sampling 1 time unit after each edge
    task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 40) begin
            @(posedge clock);
            #1;
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(o, a, b);
        check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        wait_done(n);
        check({tag, "_latency"}, n, 32'd32);
        check({tag, "_hi"}, hi_out, exp_hi);
        check({tag, "_lo"}, lo_out, exp_lo);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = 32'd0;
        b_in  = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);

        // Signed multiply
        run_op("mul_7xm3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mul_minxmin", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Signed divide
        run_op("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check("div_m7d2_dz", {31'd0, div_zero}, 32'd0);
        run_op("div_minxm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // Divide by zero after preloading HI/LO
        run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'd0, 32'd15);
        issue(1'b1, 32'd9, 32'd0);
        check("dz_done", {31'd0, done}, 32'd1);
        check("dz_flag", {31'd0, div_zero}, 32'd1);
        check("dz_busy", {31'd0, busy}, 32'd0);
        check("dz_hi", hi_out, 32'd0);
        check("dz_lo", lo_out, 32'd15);
        @(posedge clock);
        #1;
        check("dz_done_pulse", {31'd0, done}, 32'd0);
        check("dz_busy_after", {31'd0, busy}, 32'd0);
        check("dz_flag_hold", {31'd0, div_zero}, 32'd1);
        issue(1'b0, 32'd4, 32'd4);
        check("dz_clear", {31'd0, div_zero}, 32'd0);
        wait_done(n);
        check("mul_4x4_lo", lo_out, 32'd16);

        // Start while busy is ignored
        issue(1'b0, 32'd2, 32'd3);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd0;
        @(posedge clock);
        #1;
        start = 1'b0;
        a_in  = 32'hDEAD_BEEF;
        b_in  = 32'h1234_5678;
        check("busy_ign_dz", {31'd0, div_zero}, 32'd0);
        check("busy_ign_busy", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("busy_ign_latency", n, 32'd22);
        check("busy_ign_hi", hi_out, 32'd0);
        check("busy_ign_lo", lo_out, 32'd6);

        // Start in the done cycle is accepted at the next edge
        start = 1'b1;
        op    = 1'b0;
        a_in  = 32'hFFFF_FFFF;
        b_in  = 32'd10;
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done(n);
        check("b2b_latency", n, 32'd32);
        check("b2b_hi", hi_out, 32'hFFFF_FFFF);
        check("b2b_lo", lo_out, 32'hFFFF_FFF6);

        // Reset mid-operation aborts without writing a result
        issue(1'b1, 32'd100, 32'd7);
        repeat (14) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi_out, 32'd0);
        check("abort_lo", lo_out, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            @(posedge clock);
            #1;
        end
        check("abort_no_done", seen, 32'd0);
        run_op("div_100d7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time guard so the run can never hang
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mult_div.md
# mult_div

Multicycle signed multiply/divide unit that produces the HI and LO registers for the multicycle CPU datapath. Consumes the A and B register outputs on a start pulse from the control unit. Runs a radix-2 Booth multiply or a restoring divide, one iteration per clock. Drives HI/LO into the MEMtoReg write-back mux and signals completion back to the control unit.

## Interface
- No parameters; data width is fixed at 32 bits.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse from the control unit; accepted only when busy=0.
- op  in  1  operation select: 0 = MULT, 1 = DIV; sampled with start.
- a_in  in  32  operand from register A: multiplicand, or dividend. Signed two's complement.
- b_in  in  32  operand from register B: multiplier, or divisor. Signed two's complement.
- hi_out  out  32  HI register: product[63:32], or remainder.
- lo_out  out  32  LO register: product[31:0], or quotient.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  last accepted DIV had divisor 0.

## Operation
- States: IDLE, MULT, DIV. A 6-bit iteration counter is used in MULT and DIV.
- **Accept:** start=1 and busy=0 at rising edge E0.
  - a_in, b_in and op are latched into internal registers.
  - div_zero is cleared, counter is set to 0.
  - State moves to MULT or DIV.
- **MULT (Booth radix-2):**
  - Operates on a 65-bit {acc[31:0], Q[31:0], q_-1} register.
  - Each iteration examines {Q[0], q_-1}:
    - 01: add the multiplicand to acc.
    - 10: subtract the multiplicand from acc.
    - Then arithmetic-shift the whole register right by 1.
  - Result: the 64-bit signed product. HI = bits 63:32, LO = bits 31:0.
- **DIV (restoring, on magnitudes):**
  - Divides |a| by |b|, 32 iterations.
  - Quotient sign = sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Quotient truncates toward zero. LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (32-bit wraparound, no trap).
- **DIV with b_in=0:**
  - No iterations; state stays IDLE.
  - At E0: done=1 and div_zero=1. hi_out and lo_out are unchanged.
- **Completion:**
  - hi_out and lo_out are written only at completion; they hold their values otherwise.
  - div_zero holds until the next accepted start or reset.
- start while busy=1 is ignored and has no side effects. op, a_in and b_in are don't-care after E0.
- Only the internal latched operands are used during iteration; changes on a_in/b_in do not affect an operation in flight.

## Timing
- **Reset:**
  - State goes to IDLE and the counter to 0.
  - hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
  - Reset mid-operation aborts the operation with the same values; no partial result is written.
  - Reset has priority over start.
- **Normal operation:**
  - Iterations occur at edges E1..E32.
  - At E32, hi_out/lo_out are updated, state returns to IDLE, busy falls and done rises for exactly one cycle.
  - Latency from the accepting edge to valid result and done is 32 cycles.
- busy=1 during the cycles after E0 through E31 (32 cycles); busy=0 otherwise.
- start asserted in the done cycle is accepted at E33, so back-to-back operations are allowed.
- **Divide-by-zero:** done pulses at E0+1 cycle output (a registered pulse starting at E0); busy never rises.
- done and busy are never simultaneously 1.

## Test plan
- **Reset:** assert reset for 2 cycles.
  - -> hi_out=0, lo_out=0, busy=0, done=0, div_zero=0.
- **MULT:** a=7, b=0xFFFFFFFD (-3).
  - -> done exactly 32 cycles after the accept edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - Also a=b=0x80000000 -> hi=0x40000000, lo=0x00000000.
- **DIV:** a=0xFFFFFFF9 (-7), b=2.
  - -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
  - Also a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- **Divide-by-zero:** preload hi/lo via MULT 3*5 (hi=0, lo=15), then DIV a=9, b=0.
  - -> done and div_zero at 1 cycle, busy stays 0, hi=0, lo=15 unchanged.
  - A following MULT clears div_zero.
- **Start while busy:** start MULT 2*3; change operands and pulse start (op=1) at cycle 10.
  - -> ignored; result hi=0, lo=6 at cycle 32.
  - start in the done cycle -> accepted next edge; busy rises.
- **Reset mid-operation:** start DIV 100/7, assert reset at cycle 15.
  - -> busy=0, hi=lo=0, no done pulse.
  - A new DIV 100/7 then gives lo=14, hi=2.
